// File: rtl/demux_bin_stream_if.sv
// Stream bundle for demux_bin_stream: one tagged input stream, WIDTH output streams
// sharing a single payload bus.
interface demux_bin_stream_if #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic                 i_vld;
  logic                 i_rdy;
  logic [WIDTH_LOG-1:0] i_bin;
  DAT_T                 i_dat;
  logic [WIDTH-1:0]     o_vld;
  logic [WIDTH-1:0]     o_rdy;
  DAT_T                 o_dat;

  modport slave (
    input  i_vld, i_bin, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );

  modport master (
    output i_vld, i_bin, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/demux_bin_stream.sv
// Registered binary-select stream demultiplexer: one holding stage, full throughput,
// out-of-range indices are accepted, dropped and counted in a saturating counter.
module demux_bin_stream #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32,
  parameter int  CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_bin_stream_if.slave  bus,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);
  localparam int                   WIDTH_LOG = $clog2(WIDTH);
  localparam logic [WIDTH_LOG:0]   BIN_LIM   = (WIDTH_LOG+1)'(WIDTH);

  logic                 r_vld_p0;
  logic [WIDTH_LOG-1:0] r_bin_p0;
  DAT_T                 r_dat_p0;
  logic                 r_err_p0;
  logic [CNT_W-1:0]     r_cnt_p0;

  logic w_sel_rdy;
  logic w_out_xfer;
  logic w_in_xfer;
  logic w_in_range;

  assign w_sel_rdy  = bus.o_rdy[r_bin_p0];
  assign w_out_xfer = r_vld_p0 && w_sel_rdy;
  assign w_in_range = ({1'b0, bus.i_bin} < BIN_LIM);
  assign w_in_xfer  = bus.i_vld && bus.i_rdy;

  assign bus.i_rdy = !r_vld_p0 || w_sel_rdy;
  // Destination decode happens only on the registered index.
  assign bus.o_vld = r_vld_p0 ? (WIDTH'(1) << r_bin_p0) : '0;
  assign bus.o_dat = r_dat_p0;
  assign err       = r_err_p0;
  assign err_cnt   = r_cnt_p0;

  // Stage p0: holding register plus drop reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_bin_p0 <= '0;
      r_dat_p0 <= '0;
      r_err_p0 <= 1'b0;
      r_cnt_p0 <= '0;
    end else begin
      r_err_p0 <= w_in_xfer && !w_in_range;
      if (w_in_xfer && w_in_range) begin
        r_vld_p0 <= 1'b1;
        r_bin_p0 <= bus.i_bin;
        r_dat_p0 <= bus.i_dat;
      end else if (w_out_xfer) begin
        r_vld_p0 <= 1'b0;
      end
      if (w_in_xfer && !w_in_range && (r_cnt_p0 != '1))
        r_cnt_p0 <= r_cnt_p0 + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_bin_stream.sv
// Bench for demux_bin_stream: directed cases on WIDTH=4 and WIDTH=5/CNT_W=2 instances,
// then randomized traffic against a queue-based reference model.
module tb_demux_bin_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  demux_bin_stream_if #(.DAT_T(logic [7:0]), .WIDTH(4)) ia ();
  demux_bin_stream_if #(.DAT_T(logic [7:0]), .WIDTH(5)) ib ();

  logic       err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  demux_bin_stream #(.DAT_T(logic [7:0]), .WIDTH(4), .CNT_W(8)) ua (
    .clk(clk), .rst(rst), .bus(ia), .err(err_a), .err_cnt(cnt_a));
  demux_bin_stream #(.DAT_T(logic [7:0]), .WIDTH(5), .CNT_W(2)) ub (
    .clk(clk), .rst(rst), .bus(ib), .err(err_b), .err_cnt(cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the WIDTH=5 instance: at most one word in flight,
  // plus per-destination queues of every word accepted for that destination.
  typedef struct packed {logic [2:0] bin; logic [7:0] dat;} word_t;
  word_t      slot[$];
  logic [7:0] dq[5][$];
  logic       exp_err;
  int         exp_cnt;

  task automatic rnd_step(input bit drain);
    logic [4:0] exp_vld;
    bit         out_x, exp_rdy;
    @(negedge clk);
    exp_vld = (slot.size() != 0) ? (5'd1 << slot[0].bin) : 5'd0;
    chk("rnd_o_vld", ib.o_vld, exp_vld);
    if (slot.size() != 0) chk("rnd_o_dat", ib.o_dat, slot[0].dat);
    chk("rnd_err", err_b, exp_err);
    chk("rnd_err_cnt", cnt_b, exp_cnt);
    chk("rnd_onehot", ($countones(ib.o_vld) <= 1), 1);
    ib.i_vld = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
    ib.i_bin = 3'($urandom_range(0, 7));
    ib.i_dat = 8'($urandom);
    ib.o_rdy = drain ? 5'h1F : 5'($urandom);
    #1;
    out_x   = (slot.size() != 0) && ib.o_rdy[slot[0].bin];
    exp_rdy = (slot.size() == 0) || out_x;
    chk("rnd_i_rdy", ib.i_rdy, exp_rdy);
    for (int k = 0; k < 5; k++) begin
      if (ib.o_vld[k] && ib.o_rdy[k]) begin
        if (dq[k].size() == 0) chk("rnd_extra_word", dq[k].size(), 1);
        else chk("rnd_order", ib.o_dat, dq[k].pop_front());
      end
    end
    if (out_x) void'(slot.pop_front());
    exp_err = 1'b0;
    if (ib.i_vld && exp_rdy) begin
      if (ib.i_bin < 3'd5) begin
        slot.push_back(word_t'{ib.i_bin, ib.i_dat});
        dq[ib.i_bin].push_back(ib.i_dat);
      end else begin
        exp_err = 1'b1;
        if (exp_cnt < 3) exp_cnt++;
      end
    end
  endtask

  initial begin
    ia.i_vld = 1'b0; ia.i_bin = '0; ia.i_dat = '0; ia.o_rdy = 4'hF;
    ib.i_vld = 1'b0; ib.i_bin = '0; ib.i_dat = '0; ib.o_rdy = 5'h1F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_o_vld", ia.o_vld, 4'b0000);
    chk("rst_i_rdy", ia.i_rdy, 1'b1);
    chk("rst_o_dat", ia.o_dat, 8'h00);
    chk("rst_err", err_a, 1'b0);
    chk("rst_err_cnt", cnt_a, 8'd0);

    // single word to destination 2
    @(negedge clk);
    ia.i_vld = 1'b1; ia.i_bin = 2'd2; ia.i_dat = 8'hA5;
    @(negedge clk);
    ia.i_vld = 1'b0;
    chk("single_o_vld", ia.o_vld, 4'b0100);
    chk("single_o_dat", ia.o_dat, 8'hA5);
    @(negedge clk);
    chk("single_drain", ia.o_vld, 4'b0000);

    // back-to-back to every destination
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_o_vld", ia.o_vld, 4'b0001 << (i - 1));
        chk("b2b_o_dat", ia.o_dat, 8'h10 + 8'(i - 1));
      end
      ia.i_vld = (i < 4);
      ia.i_bin = 2'(i);
      ia.i_dat = 8'h10 + 8'(i);
      #1;
      if (i < 4) chk("b2b_i_rdy", ia.i_rdy, 1'b1);
    end

    // backpressure on destination 1 with a second word waiting
    @(negedge clk);
    ia.i_vld = 1'b1; ia.i_bin = 2'd1; ia.i_dat = 8'h3C; ia.o_rdy = 4'b1101;
    @(negedge clk);
    ia.i_bin = 2'd3; ia.i_dat = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_o_vld", ia.o_vld, 4'b0010);
      chk("bp_o_dat", ia.o_dat, 8'h3C);
      chk("bp_i_rdy", ia.i_rdy, 1'b0);
      @(negedge clk);
    end
    ia.o_rdy = 4'hF;
    #1;
    chk("bp_release_i_rdy", ia.i_rdy, 1'b1);
    @(negedge clk);
    ia.i_vld = 1'b0;
    chk("bp_next_o_vld", ia.o_vld, 4'b1000);
    chk("bp_next_o_dat", ia.o_dat, 8'hC3);

    // reset while holding an undelivered word
    @(negedge clk);
    ia.i_vld = 1'b1; ia.i_bin = 2'd3; ia.i_dat = 8'h77; ia.o_rdy = 4'h0;
    @(negedge clk);
    ia.i_vld = 1'b0;
    chk("mid_full_o_vld", ia.o_vld, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_o_vld", ia.o_vld, 4'b0000);
    chk("mid_rst_i_rdy", ia.i_rdy, 1'b1);
    chk("mid_rst_err_cnt", cnt_a, 8'd0);

    // out-of-range drops on WIDTH=5, CNT_W=2
    @(negedge clk);
    ib.i_vld = 1'b1; ib.i_bin = 3'd6; ib.i_dat = 8'h11;
    #1;
    chk("drop_i_rdy", ib.i_rdy, 1'b1);
    @(negedge clk);
    ib.i_vld = 1'b0;
    chk("drop_o_vld", ib.o_vld, 5'b00000);
    chk("drop_err", err_b, 1'b1);
    chk("drop_err_cnt", cnt_b, 2'd1);
    @(negedge clk);
    chk("drop_err_pulse", err_b, 1'b0);
    chk("drop_err_cnt_hold", cnt_b, 2'd1);
    for (int i = 0; i < 4; i++) begin
      ib.i_vld = 1'b1; ib.i_bin = (i % 2 == 0) ? 3'd5 : 3'd7;
      @(negedge clk);
    end
    ib.i_vld = 1'b0;
    chk("sat_err", err_b, 1'b1);
    chk("sat_err_cnt", cnt_b, 2'd3);
    @(negedge clk);
    chk("sat_err_cnt_hold", cnt_b, 2'd3);

    // randomized traffic
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_cnt = 0;
    for (int c = 0; c < 10000; c++) rnd_step(1'b0);
    for (int c = 0; c < 4; c++) rnd_step(1'b1);
    for (int k = 0; k < 5; k++) chk("rnd_lost_words", dq[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
